// File: rtl/block_warp_looper.sv
// block_warp_looper: walks the warp grid inside one block and issues warp offsets.
// Ports: bofs rdy/ack in, warp rdy/ack out (o_wofs), warpdone in, blkdone pulse out.
module block_warp_looper #(
  parameter int WBW   = 32,
  parameter int VDIM  = 6,
  parameter int N_OUT = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     bofs_rdy,
  output logic                     bofs_ack,
  input  logic [VDIM-1:0][WBW-1:0] i_bofs,
  input  logic [VDIM-1:0][WBW-1:0] i_wgrid_step,
  input  logic [VDIM-1:0][WBW-1:0] i_wgrid_end,
  input  logic [VDIM-1:0][WBW-1:0] i_bboundary,
  output logic                     warp_rdy,
  input  logic                     warp_ack,
  output logic [VDIM-1:0][WBW-1:0] o_wofs,
  input  logic                     warpdone_dval,
  output logic                     blkdone_dval
);

  localparam int OW = $clog2(N_OUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t                   state;
  logic [VDIM-1:0][WBW-1:0] base;
  logic [VDIM-1:0][WBW-1:0] cnt;
  logic [VDIM-1:0][WBW-1:0] cnt_nxt;
  logic [VDIM-1:0][WBW-1:0] sum;
  logic [OW-1:0]            outstanding;
  logic [WBW:0]             nxt;
  logic                     inb;
  logic                     wrap;
  logic                     warp_hs;
  logic                     adv;

  always_comb begin
    inb = 1'b1;
    sum = '0;
    for (int k = 0; k < VDIM; k++) begin
      sum[k] = base[k] + cnt[k];
      if (sum[k] >= i_bboundary[k]) inb = 1'b0;
    end
  end

  assign o_wofs = sum;

  // Odometer step; the sum is widened so a large step cannot wrap past end.
  always_comb begin
    wrap    = 1'b1;
    cnt_nxt = cnt;
    nxt     = '0;
    for (int k = VDIM - 1; k >= 0; k--) begin
      if (wrap) begin
        nxt = {1'b0, cnt[k]} + {1'b0, i_wgrid_step[k]};
        if (nxt >= {1'b0, i_wgrid_end[k]}) begin
          cnt_nxt[k] = '0;
        end else begin
          cnt_nxt[k] = nxt[WBW-1:0];
          wrap       = 1'b0;
        end
      end
    end
  end

  assign bofs_ack = (state == IDLE) && bofs_rdy;
  assign warp_rdy = (state == RUN) && inb &&
                    (outstanding != OW'(N_OUT));
  assign warp_hs  = warp_rdy && warp_ack;
  // Out-of-bound positions are skipped without a handshake.
  assign adv      = (state == RUN) && (warp_hs || !inb);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= IDLE;
      base         <= '0;
      cnt          <= '0;
      outstanding  <= '0;
      blkdone_dval <= 1'b0;
    end else begin
      blkdone_dval <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bofs_ack) begin
            base  <= i_bofs;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          if (adv) begin
            cnt <= cnt_nxt;
            if (wrap) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (outstanding == '0) begin
            state        <= DONE;
            blkdone_dval <= 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
      if (warp_hs && !warpdone_dval) begin
        outstanding <= outstanding + 1'b1;
      end else if (!warp_hs && warpdone_dval &&
                   outstanding != '0) begin
        outstanding <= outstanding - 1'b1;
      end
    end
  end

  assert property (@(posedge i_clk) disable iff (i_rst)
    !(warpdone_dval && outstanding == '0));

endmodule
